// File: rtl/systolic_fir_sequencer.sv
// Front/back-end controller for the 3-slice bidirectional systolic FIR array.
// Feeds samples with a zero bubble after each one, owns the weights, and buffers results.
module systolic_fir_sequencer #(
    parameter int WIDTH      = 8,
    parameter int RESULT_LAT = 1,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [1:0]              cfg_sel,
    input  logic signed [WIDTH-1:0] cfg_data,
    output logic signed [WIDTH-1:0] x_in_left,
    output logic signed [WIDTH-1:0] y_prev_right,
    output logic signed [WIDTH-1:0] w3,
    output logic signed [WIDTH-1:0] w2,
    output logic signed [WIDTH-1:0] w1,
    input  logic signed [WIDTH-1:0] results_left,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] m_data,
    output logic                    busy
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    localparam logic [0:0] ST_SAMPLE = 1'b0;
    localparam logic [0:0] ST_BUBBLE = 1'b1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]              state_q, state_d;
    logic                    run_q;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic [RESULT_LAT-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]        credits_q, credits_d;
    logic                    busy_q;
    logic signed [WIDTH-1:0] w1_q, w2_q, w3_q;

    logic signed [WIDTH-1:0] mem [OUT_DEPTH];
    logic [PTR_W-1:0]        rd_q, rd_d;
    logic [PTR_W-1:0]        wr_q, wr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    mval_q;
    logic signed [WIDTH-1:0] mdata_q, mdata_d;

    logic cfg_fire;
    logic accept;
    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // run_q keeps both handshakes closed until the first edge after reset release.
    assign cfg_ready = run_q && !busy_q && (state_q == ST_SAMPLE) && !s_valid;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign s_ready   = run_q && (state_q == ST_SAMPLE) && (credits_q < DEPTH_C) && !cfg_fire;
    assign accept    = s_valid && s_ready;
    assign push      = tag_q[RESULT_LAT-1];
    assign pop       = mval_q && m_ready;

    assign x_in_left    = x_q;
    assign y_prev_right = '0;
    assign w1           = w1_q;
    assign w2           = w2_q;
    assign w3           = w3_q;
    assign m_valid      = mval_q;
    assign m_data       = mdata_q;
    assign busy         = busy_q;

    always_comb begin
        state_d = state_q;
        x_d     = '0;
        if (state_q == ST_SAMPLE) begin
            if (accept) begin
                x_d     = s_data;
                state_d = ST_BUBBLE;
            end
        end else begin
            state_d = ST_SAMPLE;
        end

        tag_d[0] = accept;
        for (int i = 1; i < RESULT_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        case ({accept, pop})
            2'b10:   credits_d = credits_q + CNT_ONE;
            2'b01:   credits_d = credits_q - CNT_ONE;
            default: credits_d = credits_q;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        rd_d = pop  ? next_ptr(rd_q) : rd_q;
        wr_d = push ? next_ptr(wr_q) : wr_q;

        // A result written this edge into the slot that becomes the head bypasses the array.
        mdata_d = (push && (wr_q == rd_d)) ? results_left : mem[rd_d];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_SAMPLE;
            run_q     <= 1'b0;
            x_q       <= '0;
            tag_q     <= '0;
            credits_q <= '0;
            busy_q    <= 1'b0;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            mval_q    <= 1'b0;
            mdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            x_q       <= x_d;
            tag_q     <= tag_d;
            credits_q <= credits_d;
            busy_q    <= (credits_d != '0);
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            count_q   <= count_d;
            mval_q    <= (count_d != '0);
            mdata_q   <= mdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w1_q <= '0;
            w2_q <= '0;
            w3_q <= '0;
        end else if (cfg_fire) begin
            case (cfg_sel)
                2'd1:    w1_q <= cfg_data;
                2'd2:    w2_q <= cfg_data;
                2'd3:    w3_q <= cfg_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= results_left;
        end
    end

endmodule

// File: tb/tb_systolic_fir_sequencer.sv
// Bench for systolic_fir_sequencer: an abstract array/stream model checked every cycle,
// plus literal result tables that pin the model for each directed scenario.
module tb_systolic_fir_sequencer;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam logic signed [W-1:0] GARBAGE = 8'sh5A;

    logic                clk = 1'b0;
    logic                reset_n = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic signed [W-1:0] s_data = '0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [1:0]          cfg_sel = 2'd0;
    logic signed [W-1:0] cfg_data = '0;
    logic signed [W-1:0] x_in_left, y_prev_right, w3, w2, w1;
    logic signed [W-1:0] results_left;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic signed [W-1:0] m_data;
    logic                busy;

    systolic_fir_sequencer #(.WIDTH(W), .RESULT_LAT(1), .OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .x_in_left(x_in_left), .y_prev_right(y_prev_right),
        .w3(w3), .w2(w2), .w1(w1),
        .results_left(results_left),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [W-1:0] val;
        int                  avail;
    } res_t;

    // Model state, written only by the compare process.
    int total = 0, bad = 0;
    int cyc = 0, credits_m = 0, acc_cnt = 0, pop_cnt = 0, cfg_cnt = 0;
    logic bubble_m = 1'b0, nxt_has = 1'b0;
    logic signed [W-1:0] h1 = '0, h2 = '0, wm1 = '0, wm2 = '0, wm3 = '0, x_exp = '0, nxt_res = '0;
    res_t q[$];

    // Stimulus-side state, written only by the main process.
    logic chk_en = 1'b0, done = 1'b0;
    int   tmo = 0, lit_start = 0, lit_n = 0;
    int   lit [8];

    // Array stand-in: the result of a freshly loaded sample is valid for one cycle.
    always @(posedge clk) begin
        #1;
        results_left = nxt_has ? nxt_res : GARBAGE;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (done) begin
            chk("timeouts", tmo, 0);
            chk("drained_credits", credits_m, 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else if (!reset_n) begin
            chk("rst_x_in_left", int'(x_in_left), 0);
            chk("rst_w1", int'(w1), 0);
            chk("rst_w2", int'(w2), 0);
            chk("rst_w3", int'(w3), 0);
            chk("rst_m_data", int'(m_data), 0);
            chk("rst_m_valid", int'(m_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_s_ready", int'(s_ready), 0);
            chk("rst_cfg_ready", int'(cfg_ready), 0);
            q.delete();
            credits_m = 0;
            bubble_m  = 1'b0;
            h1 = '0; h2 = '0; wm1 = '0; wm2 = '0; wm3 = '0; x_exp = '0;
            nxt_has = 1'b0;
        end else if (chk_en) begin
            logic exp_mv, cfg_rdy_e, cfg_x, s_rdy_e, acc, pop;
            int   t;
            res_t e;
            exp_mv    = (q.size() > 0) && (q[0].avail <= cyc);
            cfg_rdy_e = (credits_m == 0) && !bubble_m && !s_valid;
            cfg_x     = cfg_valid && cfg_rdy_e;
            s_rdy_e   = !bubble_m && (credits_m < DEPTH) && !cfg_x;

            chk("m_valid", int'(m_valid), int'(exp_mv));
            if (exp_mv) chk("m_data", int'(m_data), int'(q[0].val));
            chk("x_in_left", int'(x_in_left), int'(x_exp));
            chk("y_prev_right", int'(y_prev_right), 0);
            chk("w1", int'(w1), int'(wm1));
            chk("w2", int'(w2), int'(wm2));
            chk("w3", int'(w3), int'(wm3));
            chk("busy", int'(busy), int'(credits_m != 0));
            chk("cfg_ready", int'(cfg_ready), int'(cfg_rdy_e));
            chk("s_ready", int'(s_ready), int'(s_rdy_e));

            acc = s_valid && s_rdy_e;
            pop = exp_mv && m_ready;
            if (pop) begin
                if (pop_cnt - lit_start < lit_n)
                    chk("lit_m_data", int'(m_data), lit[pop_cnt - lit_start]);
                void'(q.pop_front());
                pop_cnt++;
            end
            nxt_has = acc;
            if (acc) begin
                t = int'(wm3) * int'(s_data) + int'(wm2) * int'(h1) + int'(wm1) * int'(h2);
                e.val   = t[W-1:0];
                e.avail = cyc + 2;
                q.push_back(e);
                nxt_res = e.val;
                h2 = h1;
                h1 = s_data;
                acc_cnt++;
            end
            x_exp    = acc ? s_data : '0;
            bubble_m = acc;
            credits_m = credits_m + (acc ? 1 : 0) - (pop ? 1 : 0);
            if (cfg_x) begin
                cfg_cnt++;
                case (cfg_sel)
                    2'd1: wm1 = cfg_data;
                    2'd2: wm2 = cfg_data;
                    2'd3: wm3 = cfg_data;
                    default: ;
                endcase
            end
        end
        cyc++;
    end

    task automatic cfg_write(input logic [1:0] sel, input logic signed [W-1:0] v);
        int c0;
        c0 = cfg_cnt;
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_data  = v;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (cfg_cnt != c0) break;
        end
        if (cfg_cnt == c0) tmo++;
        cfg_valid = 1'b0;
    endtask

    task automatic send(input logic signed [W-1:0] v);
        int a0;
        a0 = acc_cnt;
        s_valid = 1'b1;
        s_data  = v;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (acc_cnt != a0) break;
        end
        if (acc_cnt == a0) tmo++;
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (credits_m == 0) break;
        end
        if (credits_m != 0) tmo++;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_en  = 1'b1;
        m_ready = 1'b1;

        // Impulse through w3=1, w2=2, w1=3, plus a no-op select.
        cfg_write(2'd3, 8'sd1);
        cfg_write(2'd2, 8'sd2);
        cfg_write(2'd1, 8'sd3);
        cfg_write(2'd0, 8'sd55);
        lit_start = pop_cnt; lit_n = 3;
        lit[0] = 1; lit[1] = 2; lit[2] = 3;
        send(8'sd1); send(8'sd0); send(8'sd0);
        s_valid = 1'b0;
        wait_idle();

        // All-ones weights with wrapping sums.
        cfg_write(2'd2, 8'sd1);
        cfg_write(2'd1, 8'sd1);
        lit_start = pop_cnt; lit_n = 3;
        lit[0] = 100; lit[1] = -56; lit[2] = 44;
        send(8'sd100); send(8'sd100); send(8'sd100);
        s_valid = 1'b0;
        wait_idle();

        // Backpressure: only four samples fit while the sink stalls.
        lit_start = pop_cnt; lit_n = 6;
        lit[0] = -55; lit[1] = 103; lit[2] = 6; lit[3] = 9; lit[4] = 12; lit[5] = 15;
        m_ready = 1'b0;
        send(8'sd1); send(8'sd2); send(8'sd3); send(8'sd4);
        s_data = 8'sd5;
        repeat (10) @(negedge clk);
        m_ready = 1'b1;
        send(8'sd5); send(8'sd6);
        s_valid = 1'b0;
        wait_idle();

        // Weight write held off while a result is buffered.
        lit_start = pop_cnt; lit_n = 1;
        lit[0] = 21;
        m_ready = 1'b0;
        send(8'sd10);
        s_valid   = 1'b0;
        cfg_valid = 1'b1;
        cfg_sel   = 2'd3;
        cfg_data  = 8'sd7;
        repeat (6) @(negedge clk);
        m_ready = 1'b1;
        begin
            int c0;
            c0 = cfg_cnt;
            for (int g = 0; g < 100; g++) begin
                @(negedge clk);
                if (cfg_cnt != c0) break;
            end
            if (cfg_cnt == c0) tmo++;
        end
        cfg_valid = 1'b0;
        wait_idle();

        // Reset with two results buffered, then a fresh stream with signed weights.
        m_ready = 1'b0;
        send(8'sd3); send(8'sd4);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_en  = 1'b1;
        m_ready = 1'b1;
        cfg_write(2'd3, 8'sd2);
        cfg_write(2'd2, -8'sd1);
        cfg_write(2'd1, 8'sd1);
        lit_start = pop_cnt; lit_n = 3;
        lit[0] = 10; lit[1] = -11; lit[2] = 22;
        send(8'sd5); send(-8'sd3); send(8'sd7);
        s_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        done = 1'b1;
        repeat (50) @(negedge clk);
        $display("FAIL summary_missing got=0 want=1");
        $fatal(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
